// File: rtl/sync_pkt_fifo_if.sv
// Write/read port bundle of the packet FIFO: write, commit/discard and pop requests in,
// read data, levels and status flags out.
interface sync_pkt_fifo_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 7
);
    logic                    wr_i;
    logic [P_DATA_WIDTH-1:0] data_i;
    logic                    wr_commit_i;
    logic                    wr_discard_i;
    logic                    rd_i;
    logic [P_DATA_WIDTH-1:0] data_o;
    logic [P_ADDR_WIDTH:0]   fill_level_o;
    logic                    empty_o;
    logic                    full_o;
    logic                    afull_o;
    logic                    aempty_o;
    logic                    drop_o;
    logic                    overflow_o;
    logic                    underflow_o;

    modport master (
        output wr_i, data_i, wr_commit_i, wr_discard_i, rd_i,
        input  data_o, fill_level_o, empty_o, full_o, afull_o, aempty_o,
        input  drop_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_i, data_i, wr_commit_i, wr_discard_i, rd_i,
        output data_o, fill_level_o, empty_o, full_o, afull_o, aempty_o,
        output drop_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sync_pkt_fifo.sv
// Packet FIFO with commit/rollback on the write side; only committed packets are readable.
// Read data comes from a registered RAM port (FWFT prefetch or 1-cycle read); full_o is the only write backpressure.

// Simple dual-port RAM, one clock; read data registered and held while re_i is low.
module sdp_1clk_ram #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 7
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [P_ADDR_WIDTH-1:0] waddr_i,
    input  logic [P_DATA_WIDTH-1:0] wdata_i,
    input  logic                    re_i,
    input  logic [P_ADDR_WIDTH-1:0] raddr_i,
    output logic [P_DATA_WIDTH-1:0] rdata_o
);
    logic [P_DATA_WIDTH-1:0] mem_q [2**P_ADDR_WIDTH];
    logic [P_DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

module sync_pkt_fifo #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 7,
    parameter int P_FWFT       = 1,
    parameter int P_AFULL_THR  = 120,
    parameter int P_AEMPTY_THR = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    sync_pkt_fifo_if.slave bus
);
    localparam int DEPTH = 2**P_ADDR_WIDTH;
    typedef logic [P_ADDR_WIDTH:0] ptr_t;

    ptr_t wr_spec_q, wr_spec_d;
    ptr_t wr_cmt_q,  wr_cmt_d;
    ptr_t rd_ptr_q,  rd_ptr_d;
    logic bad_q,     bad_d;
    logic drop_q,    drop_d;
    logic ovf_q,     ovf_d;
    logic unf_q,     unf_d;
    logic out_vld_q, out_vld_d;

    ptr_t used_spec, used_cmt;
    logic full, empty, cmt_avail;
    logic wr_acc, rd_acc, ram_we, ram_re;
    logic bad_eff, do_drop, do_commit;
    logic [P_DATA_WIDTH-1:0] ram_rdata;

    // Uncommitted words hold space, so fullness tracks wr_spec; readability tracks wr_cmt.
    assign used_spec = wr_spec_q - rd_ptr_q;
    assign used_cmt  = wr_cmt_q - rd_ptr_q;
    assign cmt_avail = (wr_cmt_q != rd_ptr_q);
    assign full      = (used_spec == ptr_t'(DEPTH));
    assign empty     = (P_FWFT != 0) ? ~out_vld_q : ~cmt_avail;

    assign wr_acc    = bus.wr_i & ~full;
    assign rd_acc    = bus.rd_i & ~empty;

    // A word lost to overflow poisons the packet, including a commit in that same cycle.
    assign bad_eff   = bad_q | (bus.wr_i & full);
    assign do_drop   = bus.wr_discard_i | (bus.wr_commit_i & bad_eff);
    assign do_commit = bus.wr_commit_i & ~do_drop;

    assign ram_we    = wr_acc & ~do_drop;
    assign ram_re    = (P_FWFT != 0) ? (cmt_avail & (~out_vld_q | rd_acc)) : rd_acc;

    always_comb begin
        wr_spec_d = wr_spec_q;
        wr_cmt_d  = wr_cmt_q;
        bad_d     = bad_eff;
        drop_d    = 1'b0;
        if (do_drop) begin
            wr_spec_d = wr_cmt_q;
            bad_d     = 1'b0;
            drop_d    = (wr_spec_q != wr_cmt_q) | bus.wr_i | bad_eff;
        end else begin
            wr_spec_d = wr_spec_q + ptr_t'(wr_acc);
            if (do_commit) begin
                wr_cmt_d = wr_spec_q + ptr_t'(wr_acc);
            end
        end
    end

    assign rd_ptr_d  = rd_ptr_q + ptr_t'(ram_re);
    assign out_vld_d = ram_re | (out_vld_q & ~rd_acc);
    assign ovf_d     = ovf_q | (bus.wr_i & full);
    assign unf_d     = unf_q | (bus.rd_i & empty);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_spec_q <= '0;
            wr_cmt_q  <= '0;
            rd_ptr_q  <= '0;
            bad_q     <= 1'b0;
            drop_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            wr_spec_q <= wr_spec_d;
            wr_cmt_q  <= wr_cmt_d;
            rd_ptr_q  <= rd_ptr_d;
            bad_q     <= bad_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            out_vld_q <= out_vld_d;
        end
    end

    sdp_1clk_ram #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (wr_spec_q[P_ADDR_WIDTH-1:0]),
        .wdata_i (bus.data_i),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[P_ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.data_o       = ram_rdata;
    assign bus.fill_level_o = used_cmt;
    assign bus.empty_o      = empty;
    assign bus.full_o       = full;
    assign bus.afull_o      = (used_spec >= ptr_t'(P_AFULL_THR));
    assign bus.aempty_o     = (used_cmt <= ptr_t'(P_AEMPTY_THR));
    assign bus.drop_o       = drop_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.underflow_o  = unf_q;
endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Drives identical traffic into an FWFT and a standard-read FIFO and checks both against a queue model.
module tb_sync_pkt_fifo;
    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          wr   = 1'b0;
    logic [DW-1:0] din  = '0;
    logic          cmt  = 1'b0;
    logic          dis  = 1'b0;
    logic          rd   = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_pkt_fifo_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bf ();
    sync_pkt_fifo_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bs ();

    assign bf.wr_i = wr;  assign bf.data_i = din; assign bf.wr_commit_i = cmt;
    assign bf.wr_discard_i = dis; assign bf.rd_i = rd;
    assign bs.wr_i = wr;  assign bs.data_i = din; assign bs.wr_commit_i = cmt;
    assign bs.wr_discard_i = dis; assign bs.rd_i = rd;

    sync_pkt_fifo #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FWFT(1),
                    .P_AFULL_THR(120), .P_AEMPTY_THR(4))
        u_fwft (.clk_i(clk), .rstn_i(rstn), .bus(bf));
    sync_pkt_fifo #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FWFT(0),
                    .P_AFULL_THR(120), .P_AEMPTY_THR(4))
        u_std (.clk_i(clk), .rstn_i(rstn), .bus(bs));

    // Model, index 0 = FWFT, 1 = standard. cq: committed words still in RAM; pq: open packet.
    logic [DW-1:0] cq [2][$];
    logic [DW-1:0] pq [2][$];
    logic [DW-1:0] ow [2];
    bit ov [2]   = '{0, 0};
    bit bad [2]  = '{0, 0};
    bit mdrop [2] = '{0, 0};
    bit movf [2] = '{0, 0};
    bit munf [2] = '{0, 0};

    function automatic bit m_empty(input int m);
        return (m == 0) ? !ov[m] : (cq[m].size() == 0);
    endfunction

    task automatic model_step(input int m);
        int occ;
        bit fullm, emptym, rd_acc, wr_acc, bad_eff, dropping;
        occ      = cq[m].size() + pq[m].size();
        fullm    = (occ == DEPTH);
        emptym   = m_empty(m);
        rd_acc   = rd && !emptym;
        wr_acc   = wr && !fullm;
        if (rd && emptym) munf[m] = 1;
        if (wr && fullm)  movf[m] = 1;
        bad_eff  = bad[m] || (wr && fullm);
        dropping = dis || (cmt && bad_eff);
        // Read side only sees data committed before this edge.
        if (m == 0) begin
            if ((!ov[m] || rd_acc) && cq[m].size() > 0) begin
                ow[m] = cq[m].pop_front();
                ov[m] = 1;
            end else if (rd_acc) begin
                ov[m] = 0;
            end
        end else if (rd_acc) begin
            ow[m] = cq[m].pop_front();
            ov[m] = 1;
        end
        mdrop[m] = 0;
        if (dropping) begin
            mdrop[m] = (pq[m].size() > 0) || wr || bad_eff;
            pq[m].delete();
            bad[m] = 0;
        end else begin
            if (wr_acc) pq[m].push_back(din);
            if (cmt) while (pq[m].size() > 0) cq[m].push_back(pq[m].pop_front());
            bad[m] = bad_eff;
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int m = 0; m < 2; m++) begin
                cq[m].delete(); pq[m].delete();
                ov[m] = 0; bad[m] = 0; mdrop[m] = 0; movf[m] = 0; munf[m] = 0;
            end
        end else begin
            for (int m = 0; m < 2; m++) model_step(m);
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int m, input logic [DW-1:0] d, input logic [AW:0] fl,
                            input logic e, input logic f, input logic af, input logic ae,
                            input logic dr, input logic ovf, input logic unf);
        int occ;
        string p;
        p   = (m == 0) ? "fwft" : "std";
        occ = cq[m].size() + pq[m].size();
        chk({p, ".fill"},   DW'(fl),  DW'(cq[m].size()));
        chk({p, ".empty"},  DW'(e),   DW'(m_empty(m)));
        chk({p, ".full"},   DW'(f),   DW'(occ == DEPTH));
        chk({p, ".afull"},  DW'(af),  DW'(occ >= 120));
        chk({p, ".aempty"}, DW'(ae),  DW'(cq[m].size() <= 4));
        chk({p, ".drop"},   DW'(dr),  DW'(mdrop[m]));
        chk({p, ".ovf"},    DW'(ovf), DW'(movf[m]));
        chk({p, ".unf"},    DW'(unf), DW'(munf[m]));
        if (ov[m]) chk({p, ".data"}, d, ow[m]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, bf.data_o, bf.fill_level_o, bf.empty_o, bf.full_o, bf.afull_o,
                 bf.aempty_o, bf.drop_o, bf.overflow_o, bf.underflow_o);
        cmp_inst(1, bs.data_o, bs.fill_level_o, bs.empty_o, bs.full_o, bs.afull_o,
                 bs.aempty_o, bs.drop_o, bs.overflow_o, bs.underflow_o);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] d, input logic c);
        wr = 1; din = d; cmt = c;
        tick();
        wr = 0; cmt = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " fwft.empty"},  DW'(bf.empty_o), 1);
        chk({tag, " fwft.aempty"}, DW'(bf.aempty_o), 1);
        chk({tag, " fwft.full"},   DW'(bf.full_o), 0);
        chk({tag, " fwft.afull"},  DW'(bf.afull_o), 0);
        chk({tag, " fwft.fill"},   DW'(bf.fill_level_o), 0);
        chk({tag, " fwft.drop"},   DW'(bf.drop_o), 0);
        chk({tag, " fwft.ovf"},    DW'(bf.overflow_o), 0);
        chk({tag, " std.empty"},   DW'(bs.empty_o), 1);
        chk({tag, " std.fill"},    DW'(bs.fill_level_o), 0);
        chk({tag, " std.unf"},     DW'(bs.underflow_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        check_reset_vals("reset");
        rstn = 1;
        tick();

        // Read from empty, then a single-word packet.
        rd = 1; tick(); rd = 0;
        chk("underflow fwft", DW'(bf.underflow_o), 1);
        chk("underflow std",  DW'(bs.underflow_o), 1);
        push(32'hA5A5_0001, 1);
        chk("1w std.empty after commit", DW'(bs.empty_o), 0);
        chk("1w fwft.empty at commit",   DW'(bf.empty_o), 1);
        tick();
        chk("1w fwft.data", bf.data_o, 32'hA5A5_0001);
        rd = 1; tick(); rd = 0;
        chk("1w std.data",  bs.data_o, 32'hA5A5_0001);
        chk("1w std.empty", DW'(bs.empty_o), 1);

        // Five-word packet committed on the last word.
        for (int i = 0; i < 5; i++) push(32'h100 + i, (i == 4));
        chk("5w fwft.empty at commit", DW'(bf.empty_o), 1);
        chk("5w std.fill", DW'(bs.fill_level_o), 5);
        tick();
        chk("5w fwft.empty", DW'(bf.empty_o), 0);
        chk("5w fwft.data",  bf.data_o, 32'h100);
        chk("5w fwft.fill",  DW'(bf.fill_level_o), 4);
        rd = 1; repeat (5) tick(); rd = 0;
        chk("5w drained fwft.empty", DW'(bf.empty_o), 1);
        chk("5w drained std.data", bs.data_o, 32'h104);

        // Explicit discard of a 3-word packet.
        for (int i = 0; i < 3; i++) push(32'h200 + i, 0);
        dis = 1; tick(); dis = 0;
        chk("discard drop",  DW'(bf.drop_o), 1);
        chk("discard fill",  DW'(bf.fill_level_o), 0);
        chk("discard empty", DW'(bf.empty_o), 1);
        chk("discard full",  DW'(bf.full_o), 0);
        tick();
        chk("discard drop end", DW'(bf.drop_o), 0);

        // Fill with an uncommitted packet, overflow it, forced drop on commit.
        for (int i = 0; i < DEPTH; i++) push(32'h2000 + i, 0);
        chk("ovf full",  DW'(bf.full_o), 1);
        chk("ovf afull", DW'(bs.afull_o), 1);
        chk("ovf ovf before", DW'(bf.overflow_o), 0);
        push(32'hDEAD_BEEF, 0);
        chk("ovf ovf",   DW'(bf.overflow_o), 1);
        cmt = 1; tick(); cmt = 0;
        chk("forced drop", DW'(bs.drop_o), 1);
        chk("forced full", DW'(bs.full_o), 0);
        chk("forced fill", DW'(bs.fill_level_o), 0);

        // Full packet across the address wrap, then drain it.
        for (int i = 0; i < DEPTH; i++) push(32'h3000 + i, (i == DEPTH - 1));
        chk("wrap std.fill", DW'(bs.fill_level_o), 128);
        chk("wrap fwft.full", DW'(bf.full_o), 1);
        tick();
        chk("wrap fwft.fill", DW'(bf.fill_level_o), 127);
        rd = 1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("wrap std.data", bs.data_o, 32'h3000 + i);
            chk("wrap std.fill", DW'(bs.fill_level_o), DW'(127 - i));
            if (i < DEPTH - 1) chk("wrap fwft.data", bf.data_o, 32'h3000 + i + 1);
        end
        rd = 0;
        chk("wrap std.empty",  DW'(bs.empty_o), 1);
        chk("wrap fwft.empty", DW'(bf.empty_o), 1);
        chk("wrap aempty",     DW'(bs.aempty_o), 1);
        chk("wrap afull",      DW'(bs.afull_o), 0);

        // Reset mid-packet with committed data present.
        push(32'h4000, 0);
        push(32'h4001, 1);
        for (int i = 0; i < 3; i++) push(32'h5000 + i, 0);
        #2 rstn = 0;
        #1 check_reset_vals("async reset");
        tick(); tick();
        rstn = 1;
        repeat (4) tick();
        chk("post-reset fwft.empty", DW'(bf.empty_o), 1);
        chk("post-reset std.fill",   DW'(bs.fill_level_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
